// File: rtl/uart_link_pkg.sv
// Constants and FSM encoding shared by the clocked-UART transmitter and receiver.
package uart_link_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam logic        START_BIT  = 1'b0;
  localparam logic        STOP_BIT   = 1'b1;
  localparam logic        IDLE_LVL   = 1'b1;
  localparam int unsigned FRAME_BITS = DATA_W + 2;
  localparam int unsigned WORDS      = 2;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_EDGE,
    START,
    DATA,
    STOP
  } tx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running link clock divider; flags the clk cycle that ends in a uart_clk falling edge.
module uart_baud_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic uart_clk_o,
  output logic fall_tick_c
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic             uart_clk_q, uart_clk_d;
  logic             term_c;

  // Terminal count toggles the link clock and restarts the divider.
  always_comb begin
    term_c      = (div_q == DIV_W'(CLK_DIV - 1));
    div_d       = term_c ? '0 : div_q + DIV_W'(1);
    uart_clk_d  = term_c ? ~uart_clk_q : uart_clk_q;
    fall_tick_c = term_c & uart_clk_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      uart_clk_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      uart_clk_q <= uart_clk_d;
    end
  end

  assign uart_clk_o = uart_clk_q;

endmodule

// File: rtl/uart_frame_tx.sv
// Two-word framed serializer: start, data MSB first, stop; frames back to back, line idle high.
module uart_frame_tx
  import uart_link_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned DATA_W  = uart_link_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              send,
  input  logic [DATA_W-1:0] storage_1,
  input  logic [DATA_W-1:0] storage_2,
  output logic              uart_clk,
  output logic              uart_data,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] word2_q, word2_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              word_idx_q, word_idx_d;
  logic              data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fall_tick_c;

  uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_clk_o (uart_clk),
    .fall_tick_c(fall_tick_c)
  );

  // Line changes only on the clk edge that also drops uart_clk.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    word2_d    = word2_q;
    bit_cnt_d  = bit_cnt_q;
    word_idx_d = word_idx_q;
    data_d     = data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        data_d = IDLE_LVL;
        if (send && !busy_q) begin
          shift_d    = storage_1;
          word2_d    = storage_2;
          word_idx_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = WAIT_EDGE;
        end
      end
      WAIT_EDGE: begin
        if (fall_tick_c) begin
          data_d  = START_BIT;
          state_d = START;
        end
      end
      START: begin
        if (fall_tick_c) begin
          data_d    = shift_q[DATA_W-1];
          shift_d   = shift_q << 1;
          bit_cnt_d = CNT_W'(DATA_W - 1);
          state_d   = DATA;
        end
      end
      DATA: begin
        if (fall_tick_c) begin
          if (bit_cnt_q == '0) begin
            data_d  = STOP_BIT;
            state_d = STOP;
          end else begin
            data_d    = shift_q[DATA_W-1];
            shift_d   = shift_q << 1;
            bit_cnt_d = bit_cnt_q - CNT_W'(1);
          end
        end
      end
      STOP: begin
        if (fall_tick_c) begin
          if (word_idx_q == 1'b0) begin
            shift_d    = word2_q;
            word_idx_d = 1'b1;
            data_d     = START_BIT;
            state_d    = START;
          end else begin
            data_d  = IDLE_LVL;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        data_d  = IDLE_LVL;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      word2_q    <= '0;
      bit_cnt_q  <= '0;
      word_idx_q <= 1'b0;
      data_q     <= IDLE_LVL;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      word2_q    <= word2_d;
      bit_cnt_q  <= bit_cnt_d;
      word_idx_q <= word_idx_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign uart_data = data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: table of packets on CLK_DIV=4 and CLK_DIV=1 instances plus reset/back-to-back sequences.
module tb_uart_frame_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       send4, send1;
  logic [7:0] s1_r, s2_r;
  logic       uc4, ud4, busy4, done4;
  logic       uc1, ud1, busy1, done1;
  logic       sel;
  logic       m_clk, m_data, m_busy, m_done;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  uart_frame_tx #(.CLK_DIV(4), .DATA_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .send(send4), .storage_1(s1_r), .storage_2(s2_r),
    .uart_clk(uc4), .uart_data(ud4), .busy(busy4), .done(done4)
  );

  uart_frame_tx #(.CLK_DIV(1), .DATA_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .send(send1), .storage_1(s1_r), .storage_2(s2_r),
    .uart_clk(uc1), .uart_data(ud1), .busy(busy1), .done(done1)
  );

  always_comb begin
    m_clk  = sel ? uc1   : uc4;
    m_data = sel ? ud1   : ud4;
    m_busy = sel ? busy1 : busy4;
    m_done = sel ? done1 : done4;
  end

  typedef struct {
    logic [7:0]  s1;
    logic [7:0]  s2;
    bit          div1;
    int          inject;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic set_send(input logic v);
    if (sel) send1 = v;
    else     send4 = v;
  endtask

  // Drives (unless presend) one request and watches the whole packet cycle by cycle.
  task automatic run_packet(input logic [7:0] s1, input logic [7:0] s2, input int div,
                            input int inject_t, input bit presend, input bit b2b,
                            input logic [19:0] exp, input string nm);
    logic [19:0] got = '0;
    int nb = 0, busy_cyc = 0, start_t = -1, done_cnt = 0, misalign = 0, tail_err = 0;
    bit started = 0, done_seen = 0, stop = 0;
    logic pclk, pdata;
    int bitp = 2 * div;
    int total = bitp * 23 + 8;
    if (!presend) begin
      @(negedge clk);
      s1_r = s1;
      s2_r = s2;
      set_send(1'b1);
      @(posedge clk);
      #1;
      set_send(1'b0);
    end
    pclk  = m_clk;
    pdata = m_data;
    for (int t = 0; t < total && !stop; t++) begin
      if (t > 0) begin
        @(posedge clk);
        #1;
      end
      if (done_seen && (m_busy || !m_data || m_done)) tail_err++;
      if (m_busy) busy_cyc++;
      if (t > 0 && m_data != pdata && !(pclk && !m_clk)) misalign++;
      if (started && !pclk && m_clk && nb < 20) begin
        got[19-nb] = m_data;
        nb++;
      end
      if (!started && !m_data) begin
        started = 1;
        start_t = t;
      end
      if (m_done && !done_seen) begin
        done_cnt++;
        done_seen = 1;
        if (b2b) begin
          set_send(1'b1);
          @(posedge clk);
          #1;
          set_send(1'b0);
          chk({nm, "_b2b_accept"}, int'(m_busy), 1);
          stop = 1;
        end
      end else if (m_done) begin
        done_cnt++;
      end
      if (t == inject_t) begin
        s1_r = 8'hFF;
        s2_r = 8'h00;
        set_send(1'b1);
      end
      if (t == inject_t + 1) set_send(1'b0);
      pclk  = m_clk;
      pdata = m_data;
    end
    chk({nm, "_stream"}, int'(got), int'(exp));
    chk({nm, "_nbits"}, nb, 20);
    chk({nm, "_done_pulses"}, done_cnt, 1);
    chk({nm, "_latency_ok"}, int'(start_t >= 1 && start_t <= bitp), 1);
    chk({nm, "_busy_len"}, busy_cyc, start_t + 20 * bitp);
    chk({nm, "_align"}, misalign, 0);
    if (!b2b) chk({nm, "_tail"}, tail_err, 0);
    if (presend) chk({nm, "_idle_gap"}, int'(start_t + 1 >= bitp), 1);
  endtask

  initial begin
    int last4, last1, n4, n1, wt;
    logic p4, p1;
    bit seen;

    vecs[0] = '{8'h2C, 8'h4C, 1'b0, -1, 20'b0_00101100_1_0_01001100_1};
    vecs[1] = '{8'h2C, 8'h4C, 1'b0, 40, 20'b0_00101100_1_0_01001100_1};
    vecs[2] = '{8'hA5, 8'h5A, 1'b0, -1, 20'b0_10100101_1_0_01011010_1};
    vecs[3] = '{8'h00, 8'hFF, 1'b1, -1, 20'b0_00000000_1_0_11111111_1};
    vecs[4] = '{8'h80, 8'h01, 1'b1, -1, 20'b0_10000000_1_0_00000001_1};
    vecs[5] = '{8'hFF, 8'h00, 1'b0, -1, 20'b0_11111111_1_0_00000000_1};

    rst_n = 1'b0;
    send4 = 1'b0;
    send1 = 1'b0;
    s1_r  = 8'h3C;
    s2_r  = 8'hC3;
    sel   = 1'b0;

    // Reset held while requests toggle: everything stays at reset values.
    repeat (2) @(negedge clk);
    send4 = 1'b1;
    send1 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_uart_clk", int'(uc4), 0);
    chk("rst_uart_data", int'(ud4), 1);
    chk("rst_busy", int'(busy4), 0);
    chk("rst_done", int'(done4), 0);
    chk("rst_uart_clk_div1", int'(uc1), 0);
    chk("rst_busy_div1", int'(busy1), 0);
    send4 = 1'b0;
    send1 = 1'b0;
    rst_n = 1'b1;

    // Divider cadence after release.
    last4 = -1; last1 = -1; n4 = 0; n1 = 0;
    p4 = uc4; p1 = uc1;
    for (int t = 0; t < 40; t++) begin
      @(posedge clk);
      #1;
      if (uc4 != p4) begin
        if (last4 >= 0) chk("div4_period", t - last4, 4);
        last4 = t;
        n4++;
      end
      if (uc1 != p1) begin
        if (last1 >= 0) chk("div1_period", t - last1, 1);
        last1 = t;
        n1++;
      end
      p4 = uc4;
      p1 = uc1;
    end
    chk("div4_toggles", n4, 10);
    chk("div1_toggles", n1, 40);

    // Reset during bit 3 of the first word (a zero bit) must force the line high at once.
    sel = 1'b0;
    @(negedge clk);
    s1_r  = 8'h00;
    s2_r  = 8'h00;
    send4 = 1'b1;
    @(negedge clk);
    send4 = 1'b0;
    seen = 0;
    wt = 0;
    while (!seen && wt < 20) begin
      @(posedge clk);
      #1;
      if (!ud4) seen = 1;
      wt++;
    end
    chk("midrst_start_seen", int'(seen), 1);
    repeat (44) @(posedge clk);
    #1;
    chk("midrst_pre_low", int'(ud4), 0);
    chk("midrst_pre_busy", int'(busy4), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_data_high", int'(ud4), 1);
    chk("midrst_busy_low", int'(busy4), 0);
    chk("midrst_uart_clk_low", int'(uc4), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      sel = vecs[i].div1;
      run_packet(vecs[i].s1, vecs[i].s2, vecs[i].div1 ? 1 : 4, vecs[i].inject,
                 1'b0, 1'b0, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Back-to-back: request in the cycle done is visible, then observe the second packet.
    sel = 1'b0;
    run_packet(8'h2C, 8'h4C, 4, -1, 1'b0, 1'b1, 20'b0_00101100_1_0_01001100_1, "b2b_first");
    run_packet(8'h2C, 8'h4C, 4, -1, 1'b1, 1'b0, 20'b0_00101100_1_0_01001100_1, "b2b_second");

    sel = 1'b1;
    run_packet(8'h2C, 8'h4C, 1, -1, 1'b0, 1'b1, 20'b0_00101100_1_0_01001100_1, "b2b1_first");
    run_packet(8'h2C, 8'h4C, 1, -1, 1'b1, 1'b0, 20'b0_00101100_1_0_01001100_1, "b2b1_second");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
- Serial transmitter for the controller's clocked-UART link; it is the opposite end of the receiver that fills storage_1/storage_2.
- Serializes two DATA_W-bit setting words into back-to-back frames. Each frame is a start bit, then the data bits MSB first, then a stop bit.
- Drives its own free-running uart_clk alongside uart_data, so the receiver and its edge counter can be exercised or chained directly.
- Sits between the host-side register block and the link pins.

Parameters:
- CLK_DIV, 4: uart_clk half-period in clk cycles (>=1); one bit period = 2*CLK_DIV clk cycles.
- DATA_W, 8: bits per data word.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- send  input  1  single-cycle request to transmit storage_1 then storage_2
- storage_1  input  DATA_W  first word, sampled on accepted send
- storage_2  input  DATA_W  second word, sampled on accepted send
- uart_clk  output  1  link clock, free-running, 50% duty
- uart_data  output  1  serial line, idle high
- busy  output  1  high from accepted send until the final stop bit ends
- done  output  1  one-clk pulse when the packet completes

Behaviour:
- Reset (async assert, sync release): uart_clk=0, uart_data=1, busy=0, done=0. Divider, bit counter, word index and shift register are cleared; state=IDLE.
- Reset mid-packet aborts immediately. The line returns high with no partial stop bit.
- Baud divider:
  - Counts 0..CLK_DIV-1 and toggles uart_clk at terminal count.
  - A fall_tick pulse (one clk) accompanies every 1->0 toggle.
  - Runs in all states after reset.
- Line timing:
  - uart_data changes only on the clk edge that produces fall_tick, i.e. coincident with the uart_clk falling edge.
  - The receiver samples on the rising edge, mid-bit.
- Accept rule:
  - send is accepted only when busy=0.
  - On acceptance, storage_1/storage_2 are latched and busy=1 on the next clk.
  - send while busy=1 is ignored; latched words are unaffected.
- FSM states:
  - IDLE: uart_data=1. An accepted send goes to WAIT_EDGE.
  - WAIT_EDGE: holds until the next fall_tick, then drives start bit 0 and goes to START. Worst-case latency from send to start bit is 2*CLK_DIV clk cycles.
  - START: at the next fall_tick, drives data MSB (bit DATA_W-1) and goes to DATA. The bit counter is set to DATA_W-1.
  - DATA: at each fall_tick, shifts out the next lower bit. After bit 0 has been held one bit period, drives stop bit 1 and goes to STOP.
  - STOP: at the next fall_tick:
    - if word index = 0, switch to storage_2, drive start bit 0, go to START. There is no idle gap between frames.
    - else drive 1, pulse done and clear busy on that same clk, go to IDLE.
- Packet length: 2*(DATA_W+2) bit periods from start bit to end of final stop bit (20 for DATA_W=8).
- Same-cycle send and done: send is evaluated against the busy value before the update, so it is ignored. The earliest accepted send is one clk after done.
- Counter widths: bit counter $clog2(DATA_W); divider $clog2(CLK_DIV) with a minimum of 1 bit. No wrap beyond the terminal count.

Decomposition:
- Shared package uart_link_pkg:
  - DATA_W default
  - START_BIT=0, STOP_BIT=1, IDLE_LVL=1
  - FRAME_BITS=DATA_W+2, WORDS=2
  - state enum (IDLE, WAIT_EDGE, START, DATA, STOP)
- The receiver uses the same constants.
- One sub-module, uart_baud_gen: divider producing uart_clk and fall_tick, with its own async reset.

Test Plan:
- Reset: hold rst_n=0 during activity -> uart_clk=0, uart_data=1, busy=0, done=0. After release, uart_clk toggles every CLK_DIV clks.
- Nominal packet, storage_1=8'h2C, storage_2=8'h4C, one send pulse:
  - uart_data on successive falling edges = 0 0010_1100 1 0 0100_1100 1, then stays 1.
  - busy high for 20 bit periods plus accept latency; done exactly one clk.
  - A looped-back receiver reports storage_1=8'h2C, storage_2=8'h4C.
- Busy rejection: send again mid-DATA with new values 8'hFF/8'h00 -> serialized stream still carries 8'h2C/8'h4C; no second packet.
- Reset mid-frame: assert rst_n=0 during bit 3 of word 1 -> uart_data=1 within the reset edge. After release and a new send with 8'hA5/8'h5A, a clean full packet is produced.
- Back-to-back: send on the clk after done -> accepted. The second packet's start bit follows at the next fall_tick; the line shows at least one idle-high bit period between packets.
- Edge parameter: CLK_DIV=1, storage_1=8'h00, storage_2=8'hFF -> bit period is 2 clks. Transitions align with uart_clk falling edges, and total busy time equals 40 clks plus latency.
